// File: rtl/nios_accelerometer_pio_pkg.sv
// Shared constants and helpers for the accelerometer-FIR Avalon-MM PIO blocks.
package nios_accelerometer_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

    // Warm-up counter value at which edge detection is enabled.
    localparam logic [1:0] WARM_DONE = 2'd3;

    function automatic logic [31:0] edge_select(input logic [31:0] cur,
                                                input logic [31:0] last,
                                                input int edge_type);
        case (edge_type)
            EDGE_FALL: return ~cur & last;
            EDGE_ANY:  return cur ^ last;
            default:   return cur & ~last;
        endcase
    endfunction

endpackage

// File: rtl/nios_accelerometer_fir_in_pio_if.sv
// Avalon-MM slave bus bundle for the FIR input PIO.
interface nios_accelerometer_fir_in_pio_if;
    // No waitrequest: a write commits at any posedge where chipselect & ~write_n;
    // readdata is registered every cycle from address (latency 1, chipselect ignored).
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_accelerometer_bit_sync.sv
// WIDTH-wide multi-stage synchroniser with asynchronous active-low reset.
module nios_accelerometer_bit_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/nios_accelerometer_fir_in_pio.sv
// Avalon-MM input PIO: synchronised data, sticky edge capture and a maskable irq.
module nios_accelerometer_fir_in_pio
    import nios_accelerometer_pio_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int EDGE_TYPE   = EDGE_RISE,
    parameter int IRQ_TYPE    = IRQ_EDGE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    nios_accelerometer_fir_in_pio_if.slave  bus,
    input  logic [WIDTH-1:0]                in_port,
    output logic                            irq
);

    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] wr_clear;
    logic [1:0]       warm_cnt;
    logic             wr_en;
    logic [31:0]      rd_next;
    logic             unused_wdata;

    nios_accelerometer_bit_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync_out)
    );

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wr_clear     = (wr_en && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^bus.writedata;

    // Gated until warm-up ends so inputs already high at reset release are not seen as edges.
    assign edge_hit = (warm_cnt == WARM_DONE)
                    ? WIDTH'(edge_select(32'(sync_out), 32'(prev), EDGE_TYPE))
                    : '0;

    always_comb begin
        rd_next = '0;
        case (bus.address)
            ADDR_DATA:    rd_next[WIDTH-1:0] = sync_out;
            ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecapture;
            default:      rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev         <= '0;
            warm_cnt     <= '0;
            irqmask      <= '0;
            edgecapture  <= '0;
            irq          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            prev <= sync_out;
            if (warm_cnt != WARM_DONE) warm_cnt <= warm_cnt + 2'd1;
            if (wr_en && bus.address == ADDR_IRQMASK) irqmask <= bus.writedata[WIDTH-1:0];
            // A new edge in the same cycle as a W1C keeps the bit set.
            edgecapture <= (edgecapture & ~wr_clear) | edge_hit;
            if (IRQ_TYPE == IRQ_EDGE) irq <= |(edgecapture & irqmask);
            else                      irq <= |(sync_out & irqmask);
            bus.readdata <= rd_next;
        end
    end

endmodule
